// File: rtl/jtopl_slot_reader.sv
// Slot reader for a time-multiplexed operator pipeline.
// Tracks the slot number from the zero marker and captures one requested slot.
module jtopl_slot_reader #(
    parameter int width  = 5,
    parameter int stages = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cen,
    input  logic             zero,
    input  logic [width-1:0] din,
    input  logic             req,
    input  logic [4:0]       req_slot,
    output logic             busy,
    output logic             ack,
    output logic [width-1:0] dout,
    output logic             locked,
    output logic             sync_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic [4:0] last   = 5'(stages - 1);
    localparam logic [5:0] nslots = 6'(stages);

    state_t     state, state_nx;
    logic [4:0] cnt, cur, tgt;
    logic       in_range, hit, load, cap, clr;

    assign cur      = zero ? 5'd0 : cnt;
    assign in_range = {1'b0, req_slot} < nslots;
    assign hit      = cen && (locked || zero) && (cur == tgt);
    assign busy     = (state != IDLE);
    assign ack      = (state == ACK);

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        cap      = 1'b0;
        clr      = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    if (in_range) begin
                        load     = 1'b1;
                        state_nx = WAIT;
                    end else begin
                        clr      = 1'b1;
                        state_nx = ACK;
                    end
                end
            end
            WAIT: begin
                if (hit) begin
                    cap      = 1'b1;
                    state_nx = ACK;
                end
            end
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // The counter always follows the marker, even after a sync error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= 5'd0;
            locked   <= 1'b0;
            sync_err <= 1'b0;
        end else if (cen) begin
            cnt <= (cur == last) ? 5'd0 : cur + 5'd1;
            if (zero) begin
                locked <= 1'b1;
            end
            if (locked && (zero != (cnt == 5'd0))) begin
                sync_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt  <= 5'd0;
            dout <= '0;
        end else begin
            if (load) begin
                tgt <= req_slot;
            end
            if (cap) begin
                dout <= din;
            end else if (clr) begin
                dout <= '0;
            end
        end
    end

endmodule
